// File: rtl/spi_burst_memory_if.sv
// SPI burst memory bus: serial input pins from the master and status back to it.
// Ports: sclk_pin, cs_pin, mosi_pin (master -> slave); busy, state_out, word_count (slave -> master).
interface spi_burst_memory_if;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       busy;
    logic [2:0] state_out;
    logic [7:0] word_count;

    modport master (
        output sclk_pin, cs_pin, mosi_pin,
        input  busy, state_out, word_count
    );

    modport slave (
        input  sclk_pin, cs_pin, mosi_pin,
        output busy, state_out, word_count
    );
endinterface

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave with burst read/write access to an on-chip memory array.
// Ports: clk, rst_n (sync, active low), bus (SPI pins + status), miso_pin (tri-state).

// Pin conditioner: 2-flop synchroniser, debounce filter, one-clk edge pulses.
module spi_pin_cond #(
    parameter int   DEBOUNCE = 3,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts samples that disagree with the accepted level; the
    // (DEBOUNCE+1)-th consecutive one flips the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= {2{IDLE_LVL}};
            cnt   <= '0;
            level <= IDLE_LVL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE)) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module spi_burst_memory #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEBOUNCE   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_burst_memory_if.slave bus,
    output wire               miso_pin
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MAXB  = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CW    = $clog2(MAXB + 1);

    localparam logic [CW-1:0] HDR_LAST  = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HEADER    = 3'd1,
        RD_FETCH  = 3'd2,
        RD_SHIFT  = 3'd3,
        WR_SHIFT  = 3'd4,
        WR_COMMIT = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    logic [CW-1:0]         bit_cnt;
    logic [ADDR_WIDTH-1:0] hdr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [7:0]            wcnt;
    logic [7:0]            wcnt_inc;
    logic                  fetch_ph;
    logic                  miso_q;
    logic                  miso_oe;
    logic                  we;
    logic                  busy_c;

    // Same conditioner for all three pins keeps their latency identical,
    // so MOSI is settled by the time the matching sclk pulse arrives.
    spi_pin_cond #(.DEBOUNCE(DEBOUNCE), .IDLE_LVL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .pin(bus.cs_pin),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_cond #(.DEBOUNCE(DEBOUNCE), .IDLE_LVL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin(bus.sclk_pin),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_cond #(.DEBOUNCE(DEBOUNCE), .IDLE_LVL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .pin(bus.mosi_pin),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Conditioner outputs the FSM has no use for.
    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

    assign wcnt_inc = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // cs rise beats everything, so a word finishing on that clk never commits.
    always_comb begin
        state_nx = state;
        if (cs_rise) begin
            state_nx = IDLE;
        end else if (cs_fall) begin
            state_nx = HEADER;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                HEADER:
                    if (sclk_rise && bit_cnt == HDR_LAST)
                        state_nx = mosi_lvl ? RD_FETCH : WR_SHIFT;
                RD_FETCH:
                    if (fetch_ph) state_nx = RD_SHIFT;
                RD_SHIFT:
                    if (sclk_rise && bit_cnt == WORD_LAST) state_nx = RD_FETCH;
                WR_SHIFT:
                    if (sclk_rise && bit_cnt == WORD_LAST) state_nx = WR_COMMIT;
                WR_COMMIT: state_nx = WR_SHIFT;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c  = (state != IDLE);
        miso_oe = ((state == RD_FETCH) || (state == RD_SHIFT)) && !cs_lvl;
        we      = (state == WR_COMMIT);
    end

    assign bus.busy       = busy_c;
    assign bus.state_out  = state;
    assign bus.word_count = wcnt;
    assign miso_pin       = miso_oe ? miso_q : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            hdr      <= '0;
            addr     <= '0;
            shreg    <= '0;
            wcnt     <= '0;
            fetch_ph <= 1'b0;
            miso_q   <= 1'b0;
        end else if (cs_rise) begin
            bit_cnt  <= '0;
            fetch_ph <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt  <= '0;
            wcnt     <= '0;
            fetch_ph <= 1'b0;
        end else begin
            case (state)
                HEADER:
                    if (sclk_rise) begin
                        if (bit_cnt == HDR_LAST) begin
                            addr    <= hdr;
                            bit_cnt <= '0;
                        end else begin
                            hdr     <= {hdr[ADDR_WIDTH-2:0], mosi_lvl};
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                // Phase 0 addresses the array, phase 1 takes its registered output.
                RD_FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    if (fetch_ph) shreg <= rdata;
                end
                RD_SHIFT: begin
                    if (sclk_fall) begin
                        miso_q <= shreg[DATA_WIDTH-1];
                        shreg  <= shreg << 1;
                    end
                    if (sclk_rise) begin
                        if (bit_cnt == WORD_LAST) begin
                            bit_cnt <= '0;
                            addr    <= addr + ADDR_WIDTH'(1);
                            wcnt    <= wcnt_inc;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                WR_SHIFT:
                    if (sclk_rise) begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], mosi_lvl};
                        bit_cnt <= (bit_cnt == WORD_LAST) ? '0 : bit_cnt + CW'(1);
                    end
                WR_COMMIT: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    wcnt <= wcnt_inc;
                end
                default: ;
            endcase
        end
    end

    // Contents survive reset; a write in the reset clk is suppressed.
    always_ff @(posedge clk) begin
        if (we && rst_n) mem[addr] <= shreg;
        rdata <= mem[addr];
    end
endmodule
